// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants, response record and address range helper for imem_responder
package imem_pkg;

  localparam int              DWIDTH_DEF   = 32;
  localparam int              AWIDTH_DEF   = 32;
  localparam logic [31:0]     BASEADDR_DEF = 32'h0100_0000;

  // One buffered response: echoed request address, instruction word and error flag.
  typedef struct packed {
    logic [AWIDTH_DEF-1:0] addr;
    logic [DWIDTH_DEF-1:0] data;
    logic                  err;
  } imem_rsp_t;

  // True when base <= addr < base + span. One extra bit keeps the upper bound
  // from wrapping when the window sits at the top of the address space.
  function automatic logic imem_in_range(
    input logic [AWIDTH_DEF-1:0] addr,
    input logic [AWIDTH_DEF-1:0] base,
    input logic [AWIDTH_DEF:0]   span
  );
    logic [AWIDTH_DEF:0] a_ext;
    logic [AWIDTH_DEF:0] lo_ext;
    a_ext  = {1'b0, addr};
    lo_ext = {1'b0, base};
    return (a_ext >= lo_ext) && (a_ext < (lo_ext + span));
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - two-entry response buffer with registered head
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter type T = imem_rsp_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           head,
  output logic [1:0] count
);

  T     slot0;
  T     slot1;
  logic do_push;
  logic do_pop;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt count.
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);
  assign head    = slot0;

  // Slot 0 is always the oldest entry; pops shift slot 1 forward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0 <= push_data;
          end else begin
            slot1 <= push_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder serving fetch word reads from an internal array
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DWIDTH   = DWIDTH_DEF,
  parameter int          AWIDTH   = AWIDTH_DEF,
  parameter logic [31:0] BASEADDR = BASEADDR_DEF,
  parameter int          DEPTH    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [AWIDTH-1:0] rsp_addr,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [AWIDTH-1:0] load_addr,
  input  logic [DWIDTH-1:0] load_data
);

  localparam int              IDXW = $clog2(DEPTH);
  localparam logic [AWIDTH:0] SPAN = (AWIDTH + 1)'(DEPTH) << 2;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [IDXW-1:0] req_idx;
  logic [IDXW-1:0] load_idx;
  logic            req_ok;
  logic            load_ok;
  logic            accept;
  logic            pop;
  logic [1:0]      count;
  imem_rsp_t       push_entry;
  imem_rsp_t       head;

  // Word index is the byte offset from the base divided by four, truncated to the array size.
  assign req_idx  = IDXW'((req_addr - BASEADDR) >> 2);
  assign load_idx = IDXW'((load_addr - BASEADDR) >> 2);
  assign req_ok   = imem_in_range(req_addr, BASEADDR, SPAN) && (req_addr[1:0] == 2'b00);
  assign load_ok  = imem_in_range(load_addr, BASEADDR, SPAN) && (load_addr[1:0] == 2'b00);

  // Ready depends only on buffer occupancy, never on rsp_ready or req_valid.
  assign req_ready = (count != 2'd2);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  // Build the response record; bad addresses return zero data with the error flag.
  always_comb begin
    push_entry      = '0;
    push_entry.addr = req_addr;
    push_entry.err  = !req_ok;
    push_entry.data = req_ok ? mem[req_idx] : '0;
  end

  // Program image writes; the array is never reset and loads during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && load_en && load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

  imem_rsp_fifo #(
    .T (imem_rsp_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign rsp_valid = (count != 2'd0);
  assign rsp_addr  = head.addr;
  assign rsp_data  = head.data;
  assign rsp_err   = head.err;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the fetch interface. It serves word-read requests issued by the fetch stage (PC in, instruction out) from an internal word array.
- Valid/ready request and response channels, 1-cycle read latency, 2-entry response buffer for backpressure.
- Side-band load port preloads the program image before or during simulation.

Parameters:
- DWIDTH, 32, instruction/data word width in bits.
- AWIDTH, 32, byte-address width in bits.
- BASEADDR, 32'h01000000, byte address of word 0. Reset PC of fetch.
- DEPTH, 1024, number of DWIDTH words stored. Power of two, ≥2.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  AWIDTH  byte address (PC) of requested word.
- rsp_valid  out  1  response present at buffer head.
- rsp_ready  in  1  consumer takes response this cycle.
- rsp_addr  out  AWIDTH  echo of the request address for this response.
- rsp_data  out  DWIDTH  instruction word; 0 when rsp_err=1.
- rsp_err  out  1  address misaligned or out of range.
- load_en  in  1  write one word into the array.
- load_addr  in  AWIDTH  byte address of load word.
- load_data  in  DWIDTH  word to write.

Behaviour:
- Reset (asynchronous assert): response FIFO emptied. rsp_valid=0, rsp_addr=0, rsp_data=0, rsp_err=0, req_ready=1 once rst deasserts. Array contents are NOT reset.
- Reset mid-operation: all buffered responses are dropped with no partial delivery. Loads issued while rst=1 are ignored.
- Index rule: idx = (addr − BASEADDR) >> 2, truncated to log2(DEPTH) bits.
  - In range iff BASEADDR ≤ addr < BASEADDR + 4·DEPTH, compared at full AWIDTH with no wrap.
  - Misaligned iff addr[1:0] ≠ 0.
- Accept: handshake occurs when req_valid && req_ready.
  - req_ready = (fifo_count < 2). It is purely registered-state-derived, with no combinational path from rsp_ready or req_valid.
- Latency: a request accepted at edge k has its array word read and pushed into the FIFO at edge k. rsp_valid=1 from cycle k+1.
- Response outputs are driven directly from FIFO head registers.
- Error: out-of-range or misaligned requests still produce exactly one response, with rsp_err=1 and rsp_data=0. Misaligned takes no precedence over out-of-range; either sets err.
- Pop occurs when rsp_valid && rsp_ready.
- Simultaneous push and pop with count=1: count stays 1, the new entry becomes the head. This sustains 1 response/cycle when rsp_ready is held high.
- Push and pop with count=2 cannot occur, because req_ready=0.
- Ordering: responses are returned strictly in request order.
- Stability: while rsp_valid=1 && rsp_ready=0, rsp_* are held stable.
- Load: when load_en && in range && aligned, the array is written at posedge. Otherwise the load is silently ignored.
- Load/read same cycle, same index: the response carries the OLD word (read-before-write).
- Load affects subsequent reads from the next cycle onward.
- Load is independent of the handshake and never stalls req_ready.

Decomposition:
- Package imem_pkg:
  - Default BASEADDR and DWIDTH/AWIDTH constants.
  - imem_rsp_t struct {addr, data, err}.
  - Function imem_in_range(addr) used by both the read and load paths.
- Sub-module imem_rsp_fifo: 2-entry, parameterised on imem_rsp_t, push/pop/count, with asynchronous active-high reset.
- The array and address decode remain in imem_responder.

Test Plan:
- Load words 0x00000013, 0x00100093, 0x00200113 at 0x01000000/04/08. Reset, then stream requests at those PCs with rsp_ready=1. Required: rsp at cycles k+1, k+2, k+3 with matching data and rsp_err=0, and req_ready held at 1 throughout.
- Backpressure: hold rsp_ready=0 and issue 3 requests. Required: the first two are accepted, then req_ready=0. Head holds 0x01000000/0x00000013 stable. Raise rsp_ready: both responses drain in order and req_ready returns to 1.
- Errors:
  - req_addr=0x01000002 → rsp_err=1, data=0.
  - req_addr=0x00FFFFFC and 0x01001000 (DEPTH=1024) → rsp_err=1.
  - req_addr=0x01000FFC → valid data.
- Same-cycle load 0xDEADBEEF and request to 0x01000004 (old 0x00100093). Required: response 0x00100093. The next request returns 0xDEADBEEF.
- Assert rst asynchronously (mid-cycle) with 2 responses buffered. Required: rsp_valid drops immediately without waiting for a clock edge, no stale response appears after release, and array contents are preserved (re-read of 0x01000000 returns 0x00000013).
- Randomised valid/ready toggling over 1000 requests checked against a reference queue. Required: in-order delivery, no drops or duplicates, and stability of rsp_* under stall.
